// File: rtl/proc_mem_responder_pkg.sv
// Shared types and helpers for the processor memory responder.
// Holds the loader FSM states, dmem request types and address checking.
package proc_mem_responder_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // Word aligned and inside a RAM of nwords 32-bit words.
    function automatic logic addr_ok(
        input logic [31:0] addr,
        input int unsigned nwords
    );
        return (addr[1:0] == 2'b00) &&
               ({2'b00, addr[31:2]} < nwords);
    endfunction

endpackage

// File: rtl/mem_ram_2r1w.sv
// Word RAM with two combinational read ports and one clocked write port.
// Contents are deliberately not reset so a reload is never required.
module mem_ram_2r1w #(
    parameter int NWORDS = 1024,
    parameter int W      = 32,
    parameter int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr0,
    output logic [W-1:0]  rdata0,
    input  logic [AW-1:0] raddr1,
    output logic [W-1:0]  rdata1
);

    logic [W-1:0] mem [NWORDS];

    // Single write port; reads see the old word until the next edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/proc_mem_responder.sv
// Memory responder for the processor fetch and load/store ports.
// A loader phase fills the RAM while the processor is held in reset.
module proc_mem_responder
    import proc_mem_responder_pkg::*;
#(
    parameter int NWORDS = 1024,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imemreq_val,
    input  logic [31:0]      imemreq_addr,
    output logic [31:0]      imemresp_data,
    input  logic             dmemreq_val,
    input  logic             dmemreq_type,
    input  logic [31:0]      dmemreq_addr,
    input  logic [31:0]      dmemreq_wdata,
    output logic [31:0]      dmemresp_rdata,
    input  logic             load_val,
    input  logic [31:0]      load_addr,
    input  logic [31:0]      load_data,
    input  logic             load_go,
    output logic             proc_rst,
    output logic [CNT_W-1:0] num_loads,
    output logic [CNT_W-1:0] num_stores,
    output logic             err
);

    localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned NW = NWORDS;

    state_t state;

    logic          in_load;
    logic          i_ok;
    logic          d_ok;
    logic          l_ok;
    logic          imem_hit;
    logic          d_rd;
    logic          d_wr;
    logic          l_wr;
    logic          bad_acc;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [31:0]   rdata0;
    logic [31:0]   rdata1;

    assign in_load = (state == LOAD);
    assign proc_rst = in_load;

    assign i_ok = addr_ok(imemreq_addr, NW);
    assign d_ok = addr_ok(dmemreq_addr, NW);
    assign l_ok = addr_ok(load_addr, NW);

    assign imem_hit = !in_load && imemreq_val && i_ok;
    assign d_rd = !in_load && dmemreq_val && d_ok &&
                  (dmemreq_type == MEM_READ);
    assign d_wr = !in_load && dmemreq_val && d_ok &&
                  (dmemreq_type == MEM_WRITE);
    assign l_wr = in_load && load_val && l_ok;

    // Any rejected access that the current phase is listening to.
    assign bad_acc = in_load
        ? (load_val && !l_ok)
        : ((imemreq_val && !i_ok) || (dmemreq_val && !d_ok));

    // Loader owns the write port in LOAD, the dmem port in RUN.
    always_comb begin
        we    = 1'b0;
        waddr = dmemreq_addr[AW+1:2];
        wdata = dmemreq_wdata;
        if (l_wr) begin
            we    = 1'b1;
            waddr = load_addr[AW+1:2];
            wdata = load_data;
        end else if (d_wr) begin
            we = 1'b1;
        end
    end

    mem_ram_2r1w #(
        .NWORDS (NWORDS),
        .W      (32),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr0 (imemreq_addr[AW+1:2]),
        .rdata0 (rdata0),
        .raddr1 (dmemreq_addr[AW+1:2]),
        .rdata1 (rdata1)
    );

    assign imemresp_data  = imem_hit ? rdata0 : 32'h0;
    assign dmemresp_rdata = d_rd ? rdata1 : 32'h0;

    // Loader phase ends on load_go and only rst brings it back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else if (in_load && load_go) begin
            state <= RUN;
        end
    end

    // Saturating access counters for accepted dmem traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_loads  <= '0;
            num_stores <= '0;
        end else begin
            if (d_rd && (num_loads != '1)) begin
                num_loads <= num_loads + 1'b1;
            end
            if (d_wr && (num_stores != '1)) begin
                num_stores <= num_stores + 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bad_acc) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Directed bench for proc_mem_responder with a cycle-level reference model.
// Small counters are used so saturation is reachable in a few cycles.
module tb_proc_mem_responder;

    localparam int NWORDS = 1024;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             imemreq_val;
    logic [31:0]      imemreq_addr;
    logic [31:0]      imemresp_data;
    logic             dmemreq_val;
    logic             dmemreq_type;
    logic [31:0]      dmemreq_addr;
    logic [31:0]      dmemreq_wdata;
    logic [31:0]      dmemresp_rdata;
    logic             load_val;
    logic [31:0]      load_addr;
    logic [31:0]      load_data;
    logic             load_go;
    logic             proc_rst;
    logic [CNT_W-1:0] num_loads;
    logic [CNT_W-1:0] num_stores;
    logic             err;

    int total = 0;
    int bad   = 0;

    proc_mem_responder #(
        .NWORDS (NWORDS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imemreq_val    (imemreq_val),
        .imemreq_addr   (imemreq_addr),
        .imemresp_data  (imemresp_data),
        .dmemreq_val    (dmemreq_val),
        .dmemreq_type   (dmemreq_type),
        .dmemreq_addr   (dmemreq_addr),
        .dmemreq_wdata  (dmemreq_wdata),
        .dmemresp_rdata (dmemresp_rdata),
        .load_val       (load_val),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_go        (load_go),
        .proc_rst       (proc_rst),
        .num_loads      (num_loads),
        .num_stores     (num_stores),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec-level view of memory, phase, counters, flag.
    logic [31:0] m_mem [NWORDS];
    bit          m_known [NWORDS];
    bit          m_load;
    int          m_nl;
    int          m_ns;
    bit          m_err;

    function automatic bit ok(input logic [31:0] a);
        return (a % 4 == 0) && ((a / 4) < NWORDS);
    endfunction

    initial begin
        for (int i = 0; i < NWORDS; i++) m_known[i] = 0;
        m_load = 1; m_nl = 0; m_ns = 0; m_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_load = 1; m_nl = 0; m_ns = 0; m_err = 0;
            end
            chk("m_proc_rst", 32'(proc_rst), 32'(m_load));
            chk("m_num_loads", 32'(num_loads), 32'(m_nl));
            chk("m_num_stores", 32'(num_stores), 32'(m_ns));
            chk("m_err", 32'(err), 32'(m_err));
            if (m_load || !imemreq_val || !ok(imemreq_addr))
                chk("m_imem_zero", imemresp_data, 32'h0);
            else if (m_known[imemreq_addr / 4])
                chk("m_imem", imemresp_data, m_mem[imemreq_addr / 4]);
            if (m_load || !dmemreq_val || !ok(dmemreq_addr) || dmemreq_type)
                chk("m_dmem_zero", dmemresp_rdata, 32'h0);
            else if (m_known[dmemreq_addr / 4])
                chk("m_dmem", dmemresp_rdata, m_mem[dmemreq_addr / 4]);
            @(posedge clk);
            if (!rst) begin
                if (m_load) begin
                    if (load_val && ok(load_addr)) begin
                        m_mem[load_addr / 4] = load_data;
                        m_known[load_addr / 4] = 1;
                    end
                    if (load_val && !ok(load_addr)) m_err = 1;
                    if (load_go) m_load = 0;
                end else begin
                    if (imemreq_val && !ok(imemreq_addr)) m_err = 1;
                    if (dmemreq_val && !ok(dmemreq_addr)) m_err = 1;
                    if (dmemreq_val && ok(dmemreq_addr)) begin
                        if (dmemreq_type) begin
                            m_mem[dmemreq_addr / 4] = dmemreq_wdata;
                            m_known[dmemreq_addr / 4] = 1;
                            if (m_ns < MAXC) m_ns++;
                        end else begin
                            if (m_nl < MAXC) m_nl++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imemreq_val = 0; imemreq_addr = 0;
        dmemreq_val = 0; dmemreq_type = 0;
        dmemreq_addr = 0; dmemreq_wdata = 0;
        load_val = 0; load_addr = 0; load_data = 0; load_go = 0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] d);
        tick(); idle();
        load_val = 1; load_addr = a; load_data = d;
    endtask

    task automatic dm(input logic t, input logic [31:0] a,
                      input logic [31:0] d);
        tick(); idle();
        dmemreq_val = 1; dmemreq_type = t;
        dmemreq_addr = a; dmemreq_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; idle();
        repeat (2) tick();
        @(negedge clk);
        chk("rst_proc_rst", 32'(proc_rst), 32'h1);
        chk("rst_loads", 32'(num_loads), 32'h0);
        chk("rst_stores", 32'(num_stores), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        tick(); rst = 0;
        imemreq_val = 1; imemreq_addr = 32'h40;
        dmemreq_val = 1; dmemreq_addr = 32'h0;
        @(negedge clk);
        chk("load_imem_zero", imemresp_data, 32'h0);
        chk("load_dmem_zero", dmemresp_rdata, 32'h0);

        ld(32'h000, 32'h00000013);
        ld(32'h200, 32'hcafe0123);
        ld(32'h204, 32'h11112222);
        tick(); idle(); load_go = 1;
        tick(); idle();
        @(negedge clk);
        chk("go_proc_rst", 32'(proc_rst), 32'h0);

        tick();
        imemreq_val = 1; imemreq_addr = 32'h0;
        dmemreq_val = 1; dmemreq_addr = 32'h200;
        @(negedge clk);
        chk("fetch_0", imemresp_data, 32'h00000013);
        chk("read_200", dmemresp_rdata, 32'hcafe0123);
        tick(); idle();
        @(negedge clk);
        chk("loads_1", 32'(num_loads), 32'h1);

        dm(1, 32'h204, 32'hdeadbeef);
        imemreq_val = 1; imemreq_addr = 32'h204;
        @(negedge clk);
        chk("same_cyc_old", imemresp_data, 32'h11112222);
        chk("write_rdata0", dmemresp_rdata, 32'h0);
        dm(0, 32'h204, 32'h0);
        @(negedge clk);
        chk("read_new", dmemresp_rdata, 32'hdeadbeef);
        chk("stores_1", 32'(num_stores), 32'h1);

        dm(0, 32'h202, 32'h0);
        @(negedge clk);
        chk("misalign_zero", dmemresp_rdata, 32'h0);
        dm(1, 32'h1000, 32'h12345678);
        @(negedge clk);
        chk("err_set", 32'(err), 32'h1);
        tick(); idle();
        repeat (10) tick();
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'h1);
        chk("loads_2", 32'(num_loads), 32'h2);
        chk("stores_still_1", 32'(num_stores), 32'h1);
        tick();
        imemreq_val = 1; imemreq_addr = 32'h0;
        @(negedge clk);
        chk("oob_no_write", imemresp_data, 32'h00000013);
        tick(); imemreq_addr = 32'h1000;
        @(negedge clk);
        chk("fetch_oob_zero", imemresp_data, 32'h0);

        for (int i = 0; i < 3; i++)
            dm(1, 32'h300 + 32'(4 * i), 32'(i + 1));
        tick(); idle();
        @(negedge clk);
        chk("stores_4", 32'(num_stores), 32'h4);
        tick(); rst = 1;
        #1;
        chk("mid_rst_proc_rst", 32'(proc_rst), 32'h1);
        chk("mid_rst_stores", 32'(num_stores), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);

        tick(); rst = 0;
        load_val = 1; load_addr = 32'h3; load_data = 32'h99;
        tick(); idle();
        load_val = 1; load_addr = 32'h10; load_data = 32'h55; load_go = 1;
        @(negedge clk);
        chk("bad_load_err", 32'(err), 32'h1);
        chk("still_load", 32'(proc_rst), 32'h1);
        tick(); idle();
        imemreq_val = 1; imemreq_addr = 32'h10;
        @(negedge clk);
        chk("load_and_go", imemresp_data, 32'h55);
        tick(); imemreq_addr = 32'h0;
        @(negedge clk);
        chk("ram_kept", imemresp_data, 32'h00000013);

        for (int i = 0; i < MAXC - 1; i++)
            dm(1, 32'h400 + 32'(4 * i), 32'(i));
        tick(); idle();
        @(negedge clk);
        chk("stores_max_m1", 32'(num_stores), 32'(MAXC - 1));
        for (int i = 0; i < 3; i++)
            dm(1, 32'h500 + 32'(4 * i), 32'(i));
        tick(); idle();
        @(negedge clk);
        chk("stores_sat", 32'(num_stores), 32'(MAXC));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
Synthesizable memory responder for the single-cycle processor's imem/dmem request interfaces. It is the responder for the processor's fetch and load/store requests, and the FPGA-side replacement for the behavioural test memory.
- Holds a unified word-addressed RAM with combinational reads and clocked writes.
- A loader FSM fills the RAM through a load port while holding the processor in reset.
- Keeps access counters and a sticky error flag for debug and verification.

Parameters:
NWORDS, 1024, RAM depth in 32-bit words; byte range 0 to 4*NWORDS-1
CNT_W, 32, width of the saturating access counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
imemreq_val  input  1  fetch request valid
imemreq_addr  input  32  fetch byte address
imemresp_data  output  32  fetch data, combinational
dmemreq_val  input  1  data request valid
dmemreq_type  input  1  0 = read, 1 = write
dmemreq_addr  input  32  data byte address
dmemreq_wdata  input  32  store data
dmemresp_rdata  output  32  load data, combinational
load_val  input  1  loader write strobe; honoured only in LOAD
load_addr  input  32  loader byte address
load_data  input  32  loader write data
load_go  input  1  end loading and release the processor
proc_rst  output  1  reset to the processor; high in LOAD
num_loads  output  CNT_W  count of accepted dmem reads
num_stores  output  CNT_W  count of accepted dmem writes
err  output  1  sticky access-error flag

Behaviour:
- Reset: async assert of rst forces state=LOAD, proc_rst=1, num_loads=0, num_stores=0, err=0.
  - RAM contents are not cleared by reset.
  - Mid-operation reset aborts the run immediately; RAM keeps its last contents.
- Address rules:
  - Word index = addr[31:2].
  - An access is valid when addr[1:0]==0 and addr[31:2] < NWORDS.
- LOAD state:
  - imemresp_data=0 and dmemresp_rdata=0; the imem/dmem request ports are ignored.
  - A valid load_val writes load_data at the next posedge.
  - An invalid load address is dropped and sets err.
  - load_go moves the FSM to RUN at the next posedge; proc_rst deasserts in that same edge's cycle.
  - If load_val and load_go are high in the same cycle, the write is performed, then the FSM moves to RUN.
- RUN state:
  - The load port is ignored.
  - Fetch: imemresp_data = RAM[imem index] combinationally when imemreq_val and the access is valid, else 0.
  - Read (dmemreq_val, type 0): dmemresp_rdata = RAM[index] combinationally; num_loads++ at the posedge.
  - Write (dmemreq_val, type 1): RAM[index] = wdata at the posedge; num_stores++; dmemresp_rdata=0.
  - An invalid dmem or imem access (misaligned or out of range) gives response 0, drops any write, does not count, and sets err at the posedge.
- Same-cycle ordering:
  - Any fetch or read returns the pre-write value when it targets the same word as a write in that cycle.
  - A write is visible to every access from the next cycle on.
- Counters saturate at all-ones with no wrap. err is cleared only by rst.
- FSM: LOAD -> RUN on load_go; RUN -> LOAD only on rst. There is no other transition.

Decomposition:
- Shared package holds:
  - the state enum {LOAD, RUN};
  - the dmemreq_type constants MEM_READ=0 and MEM_WRITE=1;
  - the address-check function (aligned and in range for a given NWORDS).
- One sub-module, mem_ram_2r1w: parameterised RAM with two combinational read ports and one clocked write port, no reset.
- The FSM, counters and error logic stay in proc_mem_responder.

Test Plan:
- Reset, then hold -> proc_rst=1, counters 0, err=0, and imemresp_data=0 for any address while in LOAD.
- Load 0x00000013 at 0x000 and 0xcafe0123 at 0x200, pulse load_go -> proc_rst low the next cycle; fetch 0x000 returns 0x00000013; dmem read 0x200 returns 0xcafe0123 and num_loads=1.
- RUN: write 0xdeadbeef to 0x204 while reading 0x204 in the same cycle -> read returns the old value; the next-cycle read returns 0xdeadbeef; num_stores=1.
- Dmem read at 0x202, then write to byte address 4*NWORDS -> both responses 0, no memory change, counters unchanged, err=1 and still 1 after 10 cycles.
- Assert rst mid-RUN after 3 stores -> immediate LOAD, proc_rst=1, counters 0; after load_go, a fetch of 0x000 returns the earlier-loaded 0x00000013.
- Force num_stores to all-ones minus 1, issue 3 writes -> the counter holds at all-ones.
